// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and field positions for the ALU command arbiter.
// Command layout is {op, a1, a2, a3}, three bits each.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] OP_CAS = 3'b111;

    localparam int OP_HI = 11;
    localparam int OP_LO = 9;
    localparam int A1_HI = 8;
    localparam int A1_LO = 6;
    localparam int A2_HI = 5;
    localparam int A2_LO = 3;
    localparam int A3_HI = 2;
    localparam int A3_LO = 0;

    typedef struct packed {
        logic o;
        logic c;
        logic z;
        logic n;
    } flags_t;

    function automatic logic is_cas(input logic [11:0] cmd);
        return cmd[OP_HI:OP_LO] == OP_CAS;
    endfunction

endpackage

// File: rtl/alu_cmd_arbiter_if.sv
// alu_cmd_arbiter_if: requester ports plus the ALU controller issue path.
// slave is the arbiter's view, master the surrounding system's view.
interface alu_cmd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CMD_W   = 12,
    parameter int DATA_W  = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][CMD_W-1:0] req_cmd;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_W-1:0]             rsp_data;
    logic [3:0]                    rsp_flags;
    logic                          rsp_err;
    logic                          exec_start;
    logic [CMD_W-1:0]              exec_cmd;
    logic                          exec_done;
    logic [DATA_W-1:0]             exec_result;
    logic [3:0]                    exec_flags;
    logic                          busy;
    logic [ID_W-1:0]               grant_id;

    modport slave (
        input  req_valid, req_cmd,
        input  exec_done, exec_result, exec_flags,
        output req_ready, rsp_valid, rsp_data,
        output rsp_flags, rsp_err,
        output exec_start, exec_cmd, busy, grant_id
    );

    modport master (
        output req_valid, req_cmd,
        output exec_done, exec_result, exec_flags,
        input  req_ready, rsp_valid, rsp_data,
        input  rsp_flags, rsp_err,
        input  exec_start, exec_cmd, busy, grant_id
    );

endinterface

// File: rtl/alu_cmd_arbiter_rr_picker.sv
// rr_picker: first asserted request at or after the pointer, with wrap.
// Returns a one-hot grant, its index, and whether anything was found.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req_valid[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_cmd_arbiter.sv
// alu_cmd_arbiter: round-robin owner of the single ALU command path.
// Define ALU_ARB_TIMEOUT_EN to add a WAIT-state watchdog (rsp_err).
module alu_cmd_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CMD_W   = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic rst,
    alu_cmd_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]  pick_grant;
    logic                pick_any;
    logic [NUM_REQ-1:0]  rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    flags_t              rsp_flags;
    logic                exec_start;
    logic [CMD_W-1:0]    exec_cmd;
    logic                busy;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Accept handshake is combinational so it lands in the same IDLE cycle.
    assign bus.req_ready  = (state == IDLE && !rst) ? pick_grant : '0;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data;
    assign bus.rsp_flags  = rsp_flags;
    assign bus.exec_start = exec_start;
    assign bus.exec_cmd   = exec_cmd;
    assign bus.busy       = busy;
    assign bus.grant_id   = grant_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
            exec_start <= 1'b0;
            exec_cmd   <= '0;
            busy       <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            exec_start <= 1'b0;
            rsp_valid  <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id   <= pick_idx;
                        exec_cmd   <= bus.req_cmd[pick_idx];
                        exec_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (bus.exec_done) begin
                        rsp_data  <= bus.exec_result;
                        rsp_flags <= flags_t'(bus.exec_flags);
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                        state     <= RESP;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (wait_cnt == LIMIT) begin
                        rsp_data  <= '0;
                        rsp_flags <= '0;
                        err_q     <= 1'b1;
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    rr_ptr <= (grant_id == LAST) ? '0 : grant_id + 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
                    err_q  <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
